shift_reg4_seq: RTL

Command sequencer directly upstream of the 8-bit shift_reg4 register. It accepts one command at a time over a valid/ready handshake (LOAD, SHIFT LEFT n, SHIFT RIGHT n, SERIAL-IN n). It then drives the register's enable / shift_direction / data_in pins cycle by cycle until the command completes. It signals completion with a one-cycle done pulse, so software-side logic never hand-times register controls.

---
 rtl/shift_reg4_seq.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/shift_reg4_seq.sv
// Command sequencer for the 8-bit shift_reg4 register: turns one LOAD/SHL/SHR/SERIN command into per-cycle register controls.
// Latency: enables run in cycles T+1..T+N after the accept edge T, done pulses in cycle T+N+1, ready again in cycle T+N+2.
// Backpressure: cmd_ready is low from accept until the first IDLE cycle; cmd_valid while not ready is ignored and not queued.
//
// Ports:
//   clk, reset                     - rising-edge clock, asynchronous active-high reset
//   cmd_valid/cmd_ready            - command handshake (accept when both high on a clock edge)
//   cmd_op/cmd_count/cmd_data      - opcode (00 SHL, 01 SERIN, 10 SHR, 11 LOAD), step count, load/serial data
//   abort                          - synchronous early termination of a running command
//   sr_enable/sr_shift_direction/sr_data_in - registered drive to the shift register
//   busy, done                     - not-idle flag and one-cycle completion pulse
module shift_reg4_seq #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [CNT_W-1:0]  cmd_count,
    input  logic [DATA_W-1:0] cmd_data,
    input  logic              abort,
    output logic              sr_enable,
    output logic [1:0]        sr_shift_direction,
    output logic [DATA_W-1:0] sr_data_in,
    output logic              busy,
    output logic              done
);
    // Step counters only ever need to reach DATA_W after clamping.
    localparam int SW = $clog2(DATA_W + 1);

    localparam logic [1:0] OP_SERIN = 2'b01;
    localparam logic [1:0] OP_LOAD  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [SW-1:0]     r_n;        // total enable cycles for the current command
    logic [SW-1:0]     r_k;        // index of the enable cycle currently on the outputs
    logic [DATA_W-1:0] r_data;     // serial bits still to be presented (zero for non-SERIN)
    logic              r_cmd_ready;
    logic              r_sr_enable;
    logic [1:0]        r_sr_dir;
    logic [DATA_W-1:0] r_sr_data;
    logic              r_busy;
    logic              r_done;

    logic [SW-1:0]     w_n;
    logic [SW-1:0]     w_k_next;

    // Effective step count: LOAD is always a single enable, others clamp to DATA_W.
    always_comb begin
        w_n = SW'(DATA_W);
        if (cmd_op == OP_LOAD) begin
            w_n = SW'(1);
        end else if (int'(cmd_count) <= DATA_W) begin
            w_n = SW'(cmd_count);
        end
    end

    assign w_k_next = r_k + SW'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_n         <= '0;
            r_k         <= '0;
            r_data      <= '0;
            r_cmd_ready <= 1'b1;
            r_sr_enable <= 1'b0;
            r_sr_dir    <= 2'b00;
            r_sr_data   <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid && r_cmd_ready) begin
                        r_cmd_ready <= 1'b0;
                        r_busy      <= 1'b1;
                        r_k         <= '0;
                        r_n         <= w_n;
                        // Bit 0 goes out with the first enable; the rest wait here.
                        r_data      <= (cmd_op == OP_SERIN) ? (cmd_data >> 1) : '0;
                        if (w_n == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RUN;
                            r_sr_enable <= 1'b1;
                            r_sr_dir    <= cmd_op;
                            case (cmd_op)
                                OP_LOAD:  r_sr_data <= cmd_data;
                                OP_SERIN: r_sr_data <= DATA_W'(cmd_data[0]);
                                default:  r_sr_data <= '0;
                            endcase
                        end
                    end
                end
                S_RUN: begin
                    // Abort on the final step looks exactly like normal completion.
                    if (abort || (w_k_next == r_n)) begin
                        r_state     <= S_DONE;
                        r_sr_enable <= 1'b0;
                        r_sr_dir    <= 2'b00;
                        r_sr_data   <= '0;
                        r_done      <= 1'b1;
                    end else begin
                        r_k       <= w_k_next;
                        r_sr_data <= DATA_W'(r_data[0]);
                        r_data    <= r_data >> 1;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_done      <= 1'b0;
                    r_busy      <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_n         <= '0;
                    r_k         <= '0;
                    r_data      <= '0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready          = r_cmd_ready;
    assign sr_enable          = r_sr_enable;
    assign sr_shift_direction = r_sr_dir;
    assign sr_data_in         = r_sr_data;
    assign busy               = r_busy;
    assign done               = r_done;

endmodule
